// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_t     : 4-bit MDU operation code
//   is_compute() : op occupies the unit for a multi-cycle latency
//   is_div()     : op uses the divide latency and divider result
//   is_signed_op(): op treats a/b as two's complement
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU as compute ops.
package mdu_pkg;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8,
        MADD  = 4'd9,
        MADDU = 4'd10,
        MSUB  = 4'd11,
        MSUBU = 4'd12
    } mdu_op_t;

    function automatic logic is_compute(input mdu_op_t op);
        logic r;
        r = 1'b0;
        case (op)
            MULT, MULTU, DIV, DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
    endfunction

endpackage

// File: rtl/mdu_pipe_param_if.sv
// Core <-> MDU interface.
//   start/op/a/b/cancel : issue side, driven by the core (master)
//   out                 : HI/LO read mux, driven by the MDU (slave)
//   busy/done           : in-flight flag and one-cycle commit pulse
interface mdu_pipe_param_if #(
    parameter int unsigned WIDTH = 32
);
    import mdu_pkg::*;

    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (output start, op, a, b, cancel, input out, busy, done);
    modport slave  (input start, op, a, b, cancel, output out, busy, done);

endinterface

// File: rtl/mdu_div_core.sv
// Combinational divider producing quotient and remainder.
//   a, b      : dividend / divisor
//   is_signed : two's complement (truncating toward zero, remainder takes a's sign)
//   quo, rem  : results; b==0 gives quo=all ones, rem=a;
//               signed MIN_INT / -1 gives quo=MIN_INT, rem=0
module mdu_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] min_int;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] mag_q;
    logic [WIDTH-1:0] mag_r;

    assign min_int = {1'b1, {(WIDTH-1){1'b0}}};
    assign neg_a   = is_signed & a[WIDTH-1];
    assign neg_b   = is_signed & b[WIDTH-1];
    // -MIN_INT wraps to MIN_INT, which is still the correct unsigned magnitude.
    assign mag_a   = neg_a ? -a : a;
    assign mag_b   = neg_b ? -b : b;
    assign mag_q   = mag_a / mag_b;
    assign mag_r   = mag_a % mag_b;

    always_comb begin
        quo = (neg_a ^ neg_b) ? -mag_q : mag_q;
        rem = neg_a ? -mag_r : mag_r;
        if (b == '0) begin
            quo = '1;
            rem = a;
        end else if (is_signed && (a == min_int) && (b == '1)) begin
            quo = min_int;
            rem = '0;
        end
    end

endmodule

// File: rtl/mdu_pipe_param.sv
// Parametrised multiply/divide unit with HI/LO registers (E stage).
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : start/op/a/b/cancel in; out (HI/LO read mux), busy, done out
// The result is computed when an op issues and held as a pending value; busy
// stays high for MUL_CYCLES or DIV_CYCLES cycles, then HI/LO commit with a
// one-cycle done pulse. cancel aborts an in-flight op without committing.
// Optional feature macro: MDU_MADD_EN builds the multiply-accumulate ops.
module mdu_pipe_param
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    mdu_pipe_param_if.slave bus
);

    localparam int unsigned W2      = 2 * WIDTH;
    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, last_q, last_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             op_signed;
    logic [W2-1:0]    prod_s, prod_u, prod, result;
    logic [WIDTH-1:0] quo, rem;
    logic             issue;

    assign op_signed = is_signed_op(bus.op);
    assign prod_s    = W2'($signed(bus.a)) * W2'($signed(bus.b));
    assign prod_u    = W2'(bus.a) * W2'(bus.b);
    assign prod      = op_signed ? prod_s : prod_u;

    mdu_div_core #(.WIDTH(WIDTH)) u_div (
        .a         (bus.a),
        .b         (bus.b),
        .is_signed (op_signed),
        .quo       (quo),
        .rem       (rem)
    );

    // HI/LO cannot change while busy, so the accumulate is folded in at issue.
    always_comb begin
        result = prod;
        if (is_div(bus.op)) begin
            result = {rem, quo};
        end
`ifdef MDU_MADD_EN
        if ((bus.op == MADD) || (bus.op == MADDU)) begin
            result = {hi_q, lo_q} + prod;
        end else if ((bus.op == MSUB) || (bus.op == MSUBU)) begin
            result = {hi_q, lo_q} - prod;
        end
`endif
    end

    assign issue = !busy_q && bus.start && !bus.cancel && is_compute(bus.op);

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (busy_q) begin
            if (bus.cancel) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else if (cnt_q == last_q) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                hi_d   = res_hi_q;
                lo_d   = res_lo_q;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (issue) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            res_hi_d = result[W2-1:WIDTH];
            res_lo_d = result[WIDTH-1:0];
            last_d   = is_div(bus.op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        end else if (!bus.cancel) begin
            if (bus.op == MTHI) hi_d = bus.a;
            if (bus.op == MTLO) lo_d = bus.a;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        bus.out = '0;
        if (bus.op == MFHI) bus.out = hi_q;
        if (bus.op == MFLO) bus.out = lo_q;
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_mdu_pipe_param.sv
// Scoreboard bench for mdu_pipe_param: stimulus pushes expected reads and
// expected commit latencies; monitors on the falling edge pop and compare.
module tb_mdu_pipe_param;
    import mdu_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned MUL = 5;
    localparam int unsigned DIV_LAT = 10;

    logic clk;
    logic reset_n;

    mdu_pipe_param_if #(.WIDTH(W)) bus ();

    mdu_pipe_param #(
        .WIDTH      (W),
        .MUL_CYCLES (MUL),
        .DIV_CYCLES (DIV_LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk = 0;
    int err = 0;

    logic [31:0] exp_q[$];     // expected out values for MFHI/MFLO reads
    int          commit_q[$];  // expected busy length of each committing op
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: HI/LO after an op, from the arithmetic definitions.
    function automatic logic [63:0] model(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] acc;
        logic [63:0] pu;
        sx  = $signed(x);
        sy  = $signed(y);
        acc = {h, l};
        pu  = {32'h0, x} * {32'h0, y};
        case (o)
            MULT:  return sx * sy;
            MULTU: return pu;
            DIV, DIVU: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (o == DIVU) return {x % y, x / y};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            MADD:  return acc + sx * sy;
            MADDU: return acc + pu;
            MSUB:  return acc - sx * sy;
            MSUBU: return acc - pu;
            default: return acc;
        endcase
    endfunction

    // Monitors: read values and commit timing.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.op == MFHI || bus.op == MFLO) begin
                if (exp_q.size() == 0) check("read_unexpected", 64'(bus.out), 64'hX);
                else check(bus.op == MFHI ? "read_hi" : "read_lo", 64'(bus.out), 64'(exp_q.pop_front()));
            end else if (bus.op == NOP) begin
                check("out_idle_zero", 64'(bus.out), 64'h0);
            end
            if (bus.done) begin
                if (commit_q.size() == 0) check("done_unexpected", 64'(bus.done), 64'h0);
                else check("busy_len", 64'(busy_cnt), 64'(commit_q.pop_front()));
                busy_cnt = 0;
            end else if (bus.busy) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo();
        step(); bus.op = MFHI; exp_q.push_back(m_hi);
        step(); bus.op = MFLO; exp_q.push_back(m_lo);
        step(); bus.op = NOP;
    endtask

    task automatic mt(input mdu_op_t o, input logic [31:0] v);
        step(); bus.op = o; bus.a = v;
        step(); bus.op = NOP;
        if (o == MTHI) m_hi = v; else m_lo = v;
    endtask

    // poke: 0 none, 1 start MULT while busy, 2 MTHI while busy then MFHI (old value)
    task automatic do_op(input mdu_op_t o, input logic [31:0] av, input logic [31:0] bv,
                         input int cancel_at, input int poke);
        int          lat;
        int          k;
        logic [63:0] r;
        lat = is_div(o) ? int'(DIV_LAT) : int'(MUL);
        r   = model(o, av, bv, m_hi, m_lo);
        step(); bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
        if (cancel_at == 0) commit_q.push_back(lat);
        step(); bus.start = 1'b0; bus.op = NOP;
        if (cancel_at > 0) begin
            for (int i = 1; i < cancel_at; i++) step();
            bus.cancel = 1'b1;
            step();
            bus.cancel = 1'b0;
            check("cancel_clears_busy", 64'(bus.busy), 64'h0);
            step();
        end else begin
            if (poke != 0) begin
                step();
                if (poke == 1) begin
                    bus.start = 1'b1; bus.op = MULT; bus.a = $urandom; bus.b = $urandom;
                end else begin
                    bus.op = MTHI; bus.a = 32'hA5A5_5A5A;
                end
                step();
                bus.start = 1'b0;
                bus.op = NOP;
                if (poke == 2) begin
                    bus.op = MFHI;
                    exp_q.push_back(m_hi);
                    step();
                    bus.op = NOP;
                end
            end
            k = 0;
            while (bus.busy && k < lat + 3) begin
                step();
                k++;
            end
            check("idle_within_bound", 64'(bus.busy), 64'h0);
            {m_hi, m_lo} = r;
        end
        read_hilo();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        mdu_op_t     ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          ca;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.op     = NOP;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        #1;
        check("reset_busy", 64'(bus.busy), 64'h0);
        check("reset_done", 64'(bus.done), 64'h0);
        #11 reset_n = 1'b1;
        read_hilo();

        // Directed cases
        do_op(MULT, 32'hFFFF_FFFD, 32'd5, 0, 0);
        do_op(DIVU, 32'd7, 32'd0, 0, 0);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
        mt(MTHI, 32'h1234_5678);
        read_hilo();
        mt(MTLO, 32'h0BAD_F00D);
        do_op(DIV, 32'd100, 32'd7, 0, 2);
        do_op(MULTU, 32'hFFFF_FFFF, 32'd2, 3, 0);
        do_op(MULT, 32'd9, 32'd9, MUL, 0);
        do_op(DIVU, 32'd50, 32'd3, DIV_LAT, 0);
        do_op(MULT, 32'hFFFF_0001, 32'h0001_0003, 0, 1);

        // cancel while idle blocks start and MTHI
        step(); bus.start = 1'b1; bus.op = MULT; bus.a = 32'd3; bus.b = 32'd3; bus.cancel = 1'b1;
        step(); bus.start = 1'b0; bus.op = MTHI; bus.a = 32'hDEAD_BEEF;
        check("idle_cancel_blocks_start", 64'(bus.busy), 64'h0);
        step(); bus.op = NOP; bus.cancel = 1'b0;
        read_hilo();

`ifdef MDU_MADD_EN
        mt(MTHI, 32'h0);
        mt(MTLO, 32'hFFFF_FFFF);
        do_op(MADD, 32'd1, 32'd1, 0, 0);
        do_op(MSUBU, 32'd1, 32'd2, 0, 0);
        do_op(MSUB, 32'hFFFF_FFFE, 32'd3, 0, 0);
        do_op(MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
`else
        step(); bus.start = 1'b1; bus.op = MADD; bus.a = 32'd1; bus.b = 32'd1;
        step(); bus.start = 1'b0; bus.op = NOP;
        check("madd_is_nop", 64'(bus.busy), 64'h0);
        read_hilo();
`endif

        // Randomized ops with occasional cancel and MTHI/MTLO
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: ro = MULT;
                1: ro = MULTU;
                2: ro = DIV;
                default: ro = DIVU;
            endcase
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'h0;
            if ($urandom_range(0, 7) == 0) rb = $urandom_range(1, 9);
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            ca = 0;
            if ($urandom_range(0, 3) == 0) ca = $urandom_range(1, is_div(ro) ? DIV_LAT : MUL);
            do_op(ro, ra, rb, ca, 0);
            if ($urandom_range(0, 4) == 0) mt($urandom_range(0, 1) == 0 ? MTHI : MTLO, $urandom);
        end

        // Reset mid-op: everything returns to zero at once
        step(); bus.start = 1'b1; bus.op = MULT; bus.a = 32'd6; bus.b = 32'd7;
        commit_q.push_back(MUL);
        step(); bus.start = 1'b0; bus.op = NOP;
        step();
        reset_n = 1'b0;
        commit_q.delete();
        m_hi = '0;
        m_lo = '0;
        #1;
        check("rst_mid_busy", 64'(bus.busy), 64'h0);
        check("rst_mid_done", 64'(bus.done), 64'h0);
        bus.op = MFHI;
        #1;
        check("rst_mid_hi", 64'(bus.out), 64'h0);
        bus.op = MFLO;
        #1;
        check("rst_mid_lo", 64'(bus.out), 64'h0);
        bus.op = NOP;
        step();
        reset_n = 1'b1;
        read_hilo();

        repeat (4) step();
        check("reads_drained", 64'(exp_q.size()), 64'h0);
        check("commits_drained", 64'(commit_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
